// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with prioritised redirects (branch > stall > call > return > jump > step).
// Optional return-address stack is built when the PC_RAS_EN macro is defined.
module pc_sequencer #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(100),
    parameter logic [WIDTH-1:0] INCR      = WIDTH'(4),
    parameter int               RAS_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             stall,
    input  logic                             br_taken,
    input  logic [WIDTH-1:0]                 br_target,
    input  logic                             jmp_en,
    input  logic [WIDTH-1:0]                 jmp_target,
    input  logic                             call_en,
    input  logic [WIDTH-1:0]                 call_target,
    input  logic [WIDTH-1:0]                 link_addr,
    input  logic                             ret_en,
    input  logic [WIDTH-1:0]                 ret_target,
    output logic [WIDTH-1:0]                 pc,
    output logic [WIDTH-1:0]                 pc_plus4,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count
);

    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_next_s;
    logic [WIDTH-1:0] pc_plus4_s;
    logic [WIDTH-1:0] ras_top_s;
    logic             ras_nonempty_s;
    logic             push_s;
    logic             pop_s;

    assign pc_plus4_s = pc_r + INCR;
    assign pc         = pc_r;
    assign pc_plus4   = pc_plus4_s;

    // Next-PC selection; a taken branch beats a stall, and a stall suppresses all ID-stage redirects
    always_comb begin
        pc_next_s = pc_plus4_s;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        if (br_taken) begin
            pc_next_s = br_target;
        end else if (stall) begin
            pc_next_s = pc_r;
        end else if (call_en) begin
            pc_next_s = call_target;
            push_s    = 1'b1;
        end else if (ret_en) begin
            if (ras_nonempty_s) begin
                pc_next_s = ras_top_s;
                pop_s     = 1'b1;
            end else begin
                pc_next_s = ret_target;
            end
        end else if (jmp_en) begin
            pc_next_s = jmp_target;
        end else begin
            pc_next_s = pc_plus4_s;
        end
    end

    // Fetch address register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

`ifdef PC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem_r [RAS_DEPTH];
    logic [PW-1:0]    top_r;
    logic [CW-1:0]    cnt_r;

    // Circular pointer step; depth need not be a power of two
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(RAS_DEPTH - 1)) begin
            n = '0;
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(0)) begin
            n = PW'(RAS_DEPTH - 1);
        end else begin
            n = p - PW'(1);
        end
        return n;
    endfunction

    assign ras_top_s      = ras_mem_r[top_r];
    assign ras_nonempty_s = (cnt_r != CW'(0));
    assign ras_count      = cnt_r;

    // Stack pointer and occupancy; a push when full overwrites the oldest slot and saturates the count
    always_ff @(posedge clk) begin
        if (rst) begin
            top_r <= '0;
            cnt_r <= '0;
        end else if (push_s) begin
            top_r <= ptr_inc(top_r);
            if (cnt_r != CW'(RAS_DEPTH)) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end else if (pop_s) begin
            top_r <= ptr_dec(top_r);
            cnt_r <= cnt_r - CW'(1);
        end else begin
            top_r <= top_r;
            cnt_r <= cnt_r;
        end
    end

    // Entry storage; contents are don't-care after reset so no reset is applied
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            ras_mem_r[ptr_inc(top_r)] <= link_addr;
        end else begin
            ras_mem_r[ptr_inc(top_r)] <= ras_mem_r[ptr_inc(top_r)];
        end
    end
`else
    logic unused_s;

    assign ras_top_s      = '0;
    assign ras_nonempty_s = 1'b0;
    assign ras_count      = CW'(0);
    assign unused_s       = ^{push_s, pop_s, link_addr};
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised self-checking bench for pc_sequencer against a queue-based reference model,
// plus directed reset/stall/call/return/overflow/wrap scenarios.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_en;
    logic [31:0] jmp_target;
    logic        call_en;
    logic [31:0] call_target;
    logic [31:0] link_addr;
    logic        ret_en;
    logic [31:0] ret_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [2:0]  ras_count;

    logic [7:0]  w_pc;
    logic [7:0]  w_pc_plus4;
    logic [2:0]  w_ras_count;

    int          err_cnt = 0;
    int          chk_cnt = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ras[$];

    always #5 clk = ~clk;

    pc_sequencer #(.WIDTH(32), .RESET_PC(32'd100), .INCR(32'd4), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .br_taken(br_taken), .br_target(br_target),
        .jmp_en(jmp_en), .jmp_target(jmp_target),
        .call_en(call_en), .call_target(call_target), .link_addr(link_addr),
        .ret_en(ret_en), .ret_target(ret_target),
        .pc(pc), .pc_plus4(pc_plus4), .ras_count(ras_count)
    );

    pc_sequencer #(.WIDTH(8), .RESET_PC(8'hFC), .INCR(8'd4), .RAS_DEPTH(4)) u_wrap (
        .clk(clk), .rst(rst), .stall(1'b0),
        .br_taken(1'b0), .br_target(8'h00),
        .jmp_en(1'b0), .jmp_target(8'h00),
        .call_en(1'b0), .call_target(8'h00), .link_addr(8'h00),
        .ret_en(1'b0), .ret_target(8'h00),
        .pc(w_pc), .pc_plus4(w_pc_plus4), .ras_count(w_ras_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        rst = 1'b0; stall = 1'b0; br_taken = 1'b0; jmp_en = 1'b0;
        call_en = 1'b0; ret_en = 1'b0;
        br_target = 32'd0; jmp_target = 32'd0; call_target = 32'd0;
        link_addr = 32'd0; ret_target = 32'd0;
    endtask

    // Reference: architectural next-PC rules with the RAS as a bounded LIFO queue
    task automatic model_step();
        if (rst) begin
            m_pc = 32'd100;
            m_ras.delete();
        end else if (br_taken) begin
            m_pc = br_target;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (call_en) begin
            m_pc = call_target;
`ifdef PC_RAS_EN
            m_ras.push_back(link_addr);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
`endif
        end else if (ret_en) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else m_pc = ret_target;
        end else if (jmp_en) begin
            m_pc = jmp_target;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_eq("pc_model", pc, m_pc);
        check_eq("pc_plus4_model", pc_plus4, m_pc + 32'd4);
        check_eq("ras_count_model", 32'(ras_count), 32'(m_ras.size()));
    endtask

    initial begin
        logic [31:0] ret_exp [5];
        m_pc = 32'd0;
        set_idle();
        rst = 1'b1;
        cycle();
        check_eq("reset_pc", pc, 32'd100);
        check_eq("reset_pc_plus4", pc_plus4, 32'd104);
        check_eq("reset_ras_count", 32'(ras_count), 32'd0);
        check_eq("wrap_reset_pc", 32'(w_pc), 32'h0000_00FC);
        rst = 1'b0;
        cycle();
        check_eq("step1", pc, 32'd104);
        check_eq("wrap_step", 32'(w_pc), 32'h0000_0000);
        cycle();
        check_eq("step2", pc, 32'd108);
        cycle();
        check_eq("step3", pc, 32'd112);

        // stall vs branch from pc=108
        rst = 1'b1; cycle(); rst = 1'b0;
        cycle(); cycle();
        check_eq("pre_stall", pc, 32'd108);
        stall = 1'b1;
        cycle(); check_eq("stall_hold1", pc, 32'd108);
        cycle(); check_eq("stall_hold2", pc, 32'd108);
        br_taken = 1'b1; br_target = 32'h200;
        call_en = 1'b1; call_target = 32'h900; link_addr = 32'h77;
        cycle();
        check_eq("branch_over_stall", pc, 32'h200);
        check_eq("branch_no_push", 32'(ras_count), 32'd0);
        set_idle();

`ifdef PC_RAS_EN
        call_en = 1'b1; call_target = 32'h400; link_addr = 32'h10C;
        cycle();
        check_eq("call_pc", pc, 32'h400);
        check_eq("call_count", 32'(ras_count), 32'd1);
        set_idle();
        ret_en = 1'b1; ret_target = 32'hDEAD;
        cycle();
        check_eq("ret_pc", pc, 32'h10C);
        check_eq("ret_count", 32'(ras_count), 32'd0);
        set_idle();

        for (int i = 1; i <= 5; i++) begin
            call_en = 1'b1; call_target = 32'h800 + 32'(i); link_addr = 32'(i);
            cycle();
            check_eq("ovf_push_count", 32'(ras_count), (i > 4) ? 32'd4 : 32'(i));
        end
        set_idle();
        ret_exp[0] = 32'd5; ret_exp[1] = 32'd4; ret_exp[2] = 32'd3;
        ret_exp[3] = 32'd2; ret_exp[4] = 32'hF0;
        for (int i = 0; i < 5; i++) begin
            ret_en = 1'b1; ret_target = 32'hF0;
            cycle();
            check_eq("ovf_ret_pc", pc, ret_exp[i]);
        end
        set_idle();
`else
        call_en = 1'b1; call_target = 32'h400; link_addr = 32'h10C;
        cycle();
        check_eq("nor_call_pc", pc, 32'h400);
        check_eq("nor_call_count", 32'(ras_count), 32'd0);
        set_idle();
        ret_en = 1'b1; ret_target = 32'h300;
        cycle();
        check_eq("nor_ret_pc", pc, 32'h300);
        check_eq("nor_ret_count", 32'(ras_count), 32'd0);
        set_idle();
`endif

        for (int n = 0; n < 400; n++) begin
            rst         = ($urandom_range(0, 63) == 0);
            br_taken    = ($urandom_range(0, 7) == 0);
            stall       = ($urandom_range(0, 5) == 0);
            call_en     = ($urandom_range(0, 3) == 0);
            ret_en      = ($urandom_range(0, 3) == 0);
            jmp_en      = ($urandom_range(0, 7) == 0);
            br_target   = $urandom;
            jmp_target  = $urandom;
            call_target = $urandom;
            link_addr   = $urandom;
            ret_target  = $urandom;
            cycle();
        end
        set_idle();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
